// File: rtl/pipeline_hazard_ctrl_if.sv
// Hazard controller bundle: decode/EX/MEM observations in, pipeline
// register controls and perf counters out.
interface pipeline_hazard_ctrl_if #(
   parameter int CNT_W = 16
);
   logic [6:0]       id_opcode;
   logic [4:0]       id_rs1;
   logic [4:0]       id_rs2;
   logic             ex_memread;
   logic [4:0]       ex_write_reg;
   logic             ex_branch_taken;
   logic             mem_busy;
   logic             cnt_clr;
   logic             pc_write;
   logic             pc_src_branch;
   logic             ifid_write;
   logic             ifid_flush;
   logic             idex_write;
   logic             idex_bubble;
   logic             exmem_hold;
   logic [CNT_W-1:0] stall_cycles;
   logic [CNT_W-1:0] flush_events;

   modport master (
      output id_opcode, id_rs1, id_rs2, ex_memread, ex_write_reg,
      output ex_branch_taken, mem_busy, cnt_clr,
      input  pc_write, pc_src_branch, ifid_write, ifid_flush,
      input  idex_write, idex_bubble, exmem_hold,
      input  stall_cycles, flush_events
   );

   modport slave (
      input  id_opcode, id_rs1, id_rs2, ex_memread, ex_write_reg,
      input  ex_branch_taken, mem_busy, cnt_clr,
      output pc_write, pc_src_branch, ifid_write, ifid_flush,
      output idex_write, idex_bubble, exmem_hold,
      output stall_cycles, flush_events
   );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline, with a pending-flush
// state that defers a branch flush until a memory freeze ends.
module pipeline_hazard_ctrl #(
   parameter int CNT_W = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   pipeline_hazard_ctrl_if.slave hif
);

   typedef enum logic [1:0] {
      RUN         = 2'd0,
      MEM_WAIT    = 2'd1,
      MEM_WAIT_BR = 2'd2
   } state_t;

   state_t state, state_nx;

   logic rs1_used;
   logic rs2_used;
   logic load_use;
   logic do_flush;

   always_comb begin
      rs1_used = hif.id_opcode inside
         {7'b0110011, 7'b0000011, 7'b0100011, 7'b1100011};
      rs2_used = hif.id_opcode inside
         {7'b0110011, 7'b0100011, 7'b1100011};
      load_use = hif.ex_memread && (hif.ex_write_reg != 5'd0) &&
         ((rs1_used && (hif.id_rs1 == hif.ex_write_reg)) ||
          (rs2_used && (hif.id_rs2 == hif.ex_write_reg)));
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= RUN;
      else     state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         RUN, MEM_WAIT: begin
            if (hif.mem_busy && hif.ex_branch_taken) state_nx = MEM_WAIT_BR;
            else if (hif.mem_busy)                   state_nx = MEM_WAIT;
            else                                     state_nx = RUN;
         end
         MEM_WAIT_BR: begin
            if (!hif.mem_busy) state_nx = RUN;
         end
         default: state_nx = RUN;
      endcase
   end

   // Action priority: freeze, then flush (live or pending), then load stall
   always_comb begin
      hif.pc_write      = 1'b0;
      hif.pc_src_branch = 1'b0;
      hif.ifid_write    = 1'b0;
      hif.ifid_flush    = 1'b0;
      hif.idex_write    = 1'b0;
      hif.idex_bubble   = 1'b0;
      hif.exmem_hold    = 1'b0;
      do_flush          = 1'b0;
      if (rst) begin
         do_flush = 1'b0;
      end else if (hif.mem_busy) begin
         hif.exmem_hold = 1'b1;
      end else if (state == MEM_WAIT_BR || hif.ex_branch_taken) begin
         do_flush          = 1'b1;
         hif.pc_write      = 1'b1;
         hif.pc_src_branch = 1'b1;
         hif.ifid_write    = 1'b1;
         hif.ifid_flush    = 1'b1;
         hif.idex_write    = 1'b1;
         hif.idex_bubble   = 1'b1;
      end else if (load_use) begin
         hif.idex_write  = 1'b1;
         hif.idex_bubble = 1'b1;
      end else begin
         hif.pc_write   = 1'b1;
         hif.ifid_write = 1'b1;
         hif.idex_write = 1'b1;
      end
   end

   logic [CNT_W-1:0] stall_q;
   logic [CNT_W-1:0] flush_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stall_q <= '0;
         flush_q <= '0;
      end else if (hif.cnt_clr) begin
         stall_q <= '0;
         flush_q <= '0;
      end else begin
         if (!hif.pc_write && stall_q != '1) stall_q <= stall_q + 1'b1;
         if (do_flush && flush_q != '1)      flush_q <= flush_q + 1'b1;
      end
   end

   assign hif.stall_cycles = stall_q;
   assign hif.flush_events = flush_q;

endmodule
